// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The master side produces operands and accepts results; the slave side is the adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
  logic             Ovf;

  modport master (
    output in_valid, A, B, C_in, Sub, out_ready,
    input  in_ready, out_valid, Sum, C_out, Ovf
  );

  modport slave (
    input  in_valid, A, B, C_in, Sub, out_ready,
    output in_ready, out_valid, Sum, C_out, Ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder/subtractor built from 4-bit lookahead groups, one group per stage,
// with a global-stall valid/ready pipeline. Latency WIDTH/4 edges, throughput 1/clk.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned N = WIDTH / 4;

  // Operand and sum fields are kept shifted: the next nibble to add always sits at
  // [3:0], and finished sum nibbles enter from the top, landing in place after N stages.
  logic [N-1:0]     r_v;
  logic [N-1:0]     r_c;
  logic [N-1:0]     r_cm;
  logic [WIDTH-1:0] r_sum [N];
  logic [WIDTH-1:0] r_a   [N];
  logic [WIDTH-1:0] r_b   [N];

  logic [N-1:0]     w_nv;
  logic [N-1:0]     w_nc;
  logic [N-1:0]     w_ncm;
  logic [WIDTH-1:0] w_nsum [N];
  logic [WIDTH-1:0] w_na   [N];
  logic [WIDTH-1:0] w_nb   [N];
  logic [WIDTH-1:0] w_bx;
  logic             w_stall;

  // Returns {c4, c3, sum[3:0]}; every carry is a flat sum-of-products of G/P/c0.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, c3, p ^ {c3, c2, c1, c0}};
  endfunction

  assign w_bx    = bus.Sub ? ~bus.B : bus.B;
  assign w_stall = r_v[N-1] & ~bus.out_ready;

  always_comb begin
    w_nv   = '0;
    w_nc   = '0;
    w_ncm  = '0;
    w_nsum = '{default: '0};
    w_na   = '{default: '0};
    w_nb   = '{default: '0};
    for (int unsigned i = 0; i < N; i++) begin
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] s_in;
      logic             c0;
      logic             vin;
      logic [5:0]       grp;
      if (i == 0) begin
        a_rem = bus.A;
        b_rem = w_bx;
        s_in  = '0;
        c0    = bus.Sub | bus.C_in;
        vin   = bus.in_valid;
      end else begin
        a_rem = r_a[i-1];
        b_rem = r_b[i-1];
        s_in  = r_sum[i-1];
        c0    = r_c[i-1];
        vin   = r_v[i-1];
      end
      grp       = cla4(a_rem[3:0], b_rem[3:0], c0);
      w_nv[i]   = vin;
      w_nc[i]   = grp[5];
      w_ncm[i]  = grp[4];
      w_nsum[i] = (s_in >> 4) | (WIDTH'(grp[3:0]) << (WIDTH - 4));
      w_na[i]   = a_rem >> 4;
      w_nb[i]   = b_rem >> 4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_cm  <= '0;
      r_sum <= '{default: '0};
      r_a   <= '{default: '0};
      r_b   <= '{default: '0};
    end else if (!w_stall) begin
      r_v   <= w_nv;
      r_c   <= w_nc;
      r_cm  <= w_ncm;
      r_sum <= w_nsum;
      r_a   <= w_na;
      r_b   <= w_nb;
    end
  end

  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_v[N-1];
  assign bus.Sum       = r_sum[N-1];
  assign bus.C_out     = r_c[N-1];
  assign bus.Ovf       = r_c[N-1] ^ r_cm[N-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed corner cases, latency,
// reset, backpressure and a randomized stream scored against an arithmetic model.
module tb_pipelined_cla_adder;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();
  pipelined_cla_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } res_t;

  res_t exp_q[$];

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sb);
    res_t r;
    longint unsigned tot;
    longint sa, sbv, sr;
    longint lo, hi;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lo  = -(64'sd1 <<< (WIDTH - 1));
    hi  = (64'sd1 <<< (WIDTH - 1)) - 1;
    if (sb) begin
      tot = longint'(a) + (64'd1 << WIDTH) - longint'(b);
      sr  = sa - sbv;
    end else begin
      tot = longint'(a) + longint'(b) + longint'(ci);
      sr  = sa + sbv + longint'(ci);
    end
    r.s = tot[WIDTH-1:0];
    r.c = tot[WIDTH];
    r.v = (sr < lo) || (sr > hi);
    return r;
  endfunction

  logic             was_stall = 1'b0;
  logic [WIDTH+2:0] snap      = '0;

  // Called #1 after a rising edge; drives one cycle, scores it, advances to the next.
  task automatic run_cycle(input logic iv, input logic ordy,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci, input logic sb,
                           output logic acc, output logic hs);
    logic stall_now;
    res_t e;
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.C_in      = ci;
    bus.Sub       = sb;
    bus.out_ready = ordy;
    #1;
    stall_now = bus.out_valid && !ordy;
    check("in_ready", bus.in_ready, !stall_now);
    if (was_stall)
      check("hold", {bus.out_valid, bus.Sum, bus.C_out, bus.Ovf}, snap);
    was_stall = stall_now;
    snap      = {bus.out_valid, bus.Sum, bus.C_out, bus.Ovf};
    acc = iv && bus.in_ready;
    hs  = bus.out_valid && ordy;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("spurious", bus.out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum", bus.Sum, e.s);
        check("cout", bus.C_out, e.c);
        check("ovf", bus.Ovf, e.v);
      end
    end
    if (acc) exp_q.push_back(model(a, b, ci, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic ci, input logic sb,
                     input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int unsigned lat;
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.C_in      = ci;
    bus.Sub       = sb;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = WIDTH'($urandom);
    bus.B        = WIDTH'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 4 * N + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, N);
    check({tag, "_sum"}, bus.Sum, es);
    check({tag, "_cout"}, bus.C_out, ec);
    check({tag, "_ovf"}, bus.Ovf, eo);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return WIDTH'(1) << (WIDTH - 1);
      3:       return ~(WIDTH'(1) << (WIDTH - 1));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    logic acc, hs;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    int unsigned sent, got, cnt, stall_left;
    logic stall_started;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.C_in = 1'b0; bus.Sub = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.A = WIDTH'($urandom); bus.B = WIDTH'($urandom);
      bus.C_in = 1'($urandom);  bus.Sub = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_ovalid", bus.out_valid, 1'b0);
      check("rst_sum", bus.Sum, '0);
      check("rst_cout", bus.C_out, 1'b0);
      check("rst_ovf", bus.Ovf, 1'b0);
      check("rst_iready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir("cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    dir("povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir("sovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    dir("borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir("eq",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Mid-flight reset with 3 beats queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = WIDTH'($urandom); bus.B = WIDTH'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 4 * N + 4) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("mf_ovalid_before", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mf_ovalid_async", bus.out_valid, 1'b0);
    check("mf_sum_async", bus.Sum, '0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < 3 * N; i++) begin
      if (bus.out_valid) cnt++;
      @(posedge clk);
      #1;
    end
    check("mf_no_stale", cnt, 0);

    // Backpressure: 8 back-to-back beats, 3-cycle stall once results appear
    was_stall = 1'b0;
    sent = 0; got = 0; stall_left = 0; stall_started = 1'b0;
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (!stall_started && bus.out_valid) begin
        stall_started = 1'b1;
        stall_left    = 3;
      end
      if (stall_started && stall_left == 0 && got < 8)
        check("bp_nogap", bus.out_valid, 1'b1);
      run_cycle(sent < 8, !(stall_left > 0), ra, rb, rc, rs, acc, hs);
      if (stall_left > 0) stall_left--;
      if (acc) begin
        sent++;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      end
      if (hs) got++;
    end
    check("bp_count", got, 8);
    check("bp_stalled", stall_started, 1'b1);

    // Randomized stream with random valid/ready
    for (int cyc = 0; cyc < 3000; cyc++) begin
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), acc, hs);
    end
    for (int cyc = 0; cyc < 4 * N + 8 && (exp_q.size() != 0 || bus.out_valid); cyc++)
      run_cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc, hs);
    check("drain_empty", exp_q.size(), 0);
    check("drain_ovalid", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
